fpu_issue_ctrl: RTL

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: latches an operand pair, waits a fixed compute window, then holds the captured result.
// Optional FPU_ISSUE_OPCOUNT_EN adds a 16-bit completed-result counter (op_count).
module fpu_issue_ctrl #(
  parameter int unsigned WAIT_CYCLES = 100
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic [31:0] res_data,
  output logic [3:0]  res_status,
  output logic        res_valid,
  input  logic        res_ready,
  input  logic        abort
`ifdef FPU_ISSUE_OPCOUNT_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OC_W  = 16;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, capture, handshake;

  // Next-state, counter and strobe decode; abort dominates every other event.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && in_valid) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (res_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and registered outputs; handshake flags follow the next state.
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_A_out   <= '0;
      op_B_out   <= '0;
      res_data   <= '0;
      res_status <= '0;
      res_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= (state_nxt == IDLE);
      res_valid <= (state_nxt == HOLD);
      if (accept) begin
        op_A_out <= in_A;
        op_B_out <= in_B;
      end
      if (capture) begin
        res_data   <= fpu_data;
        res_status <= fpu_status;
      end
    end
  end

`ifdef FPU_ISSUE_OPCOUNT_EN
  // Counts accepted results only; aborted operations never reach a handshake.
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      op_count <= '0;
    end else if (handshake) begin
      op_count <= op_count + OC_W'(1);
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule
